// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch-stage control slice
//
// Purpose: fetch-controller state encoding, fetch PC-mux select encoding
//          and register-index width shared by the fetch control blocks.
// Ports:   none (package).

package mips_pkg;

  localparam int REG_W = 5;

  // Fetch PC-mux select, formed as {if_stall, if_redirect}.
  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_HOLD   = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts cycles with inc=1. It stops at all-ones and never wraps.
//          A synchronous clear takes priority over an increment in the same cycle.
// Ports:   clk   - rising-edge clock
//          rst_n - asynchronous active-low reset (count -> 0)
//          clr   - synchronous clear
//          inc   - increment request for this cycle
//          count - current count [WIDTH-1:0]

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - load-use stall and branch redirect/flush control for MIPS fetch
//
// Purpose: detects load-use hazards between decode and execute and reacts to
//          taken branches. A Moore FSM drives the fetch stall, redirect and
//          flush controls. Two saturating counters record stall and flush cycles.
// Ports:   clk, rst_n              - clock, asynchronous active-low reset
//          id_rs, id_rt            - decode source register fields
//          id_uses_rt              - decode instruction reads rt
//          ex_mem_read, ex_rt      - execute-stage load and its destination
//          branch_taken            - branch/jump resolved taken
//          branch_target           - taken target byte address
//          cnt_clr                 - synchronous clear of both counters
//          if_stall, if_redirect   - PC-mux select {if_stall, if_redirect}
//          if_redirect_addr        - captured branch target
//          ifid_flush, idex_bubble - pipeline register NOP controls
//          stall_cnt, flush_cnt    - saturating cycle counters

module fetch_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               cnt_clr,
  output logic               if_stall,
  output logic               if_redirect,
  output logic [31:0]        if_redirect_addr,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  // The remain counter only ever holds values up to max(L, P) - 1.
  localparam int REM_MAX    = (LOAD_STALL_CYCLES > BRANCH_PENALTY) ? LOAD_STALL_CYCLES
                                                                   : BRANCH_PENALTY;
  localparam int REM_W      = (REM_MAX > 1) ? $clog2(REM_MAX) : 1;
  localparam int STALL_INIT = LOAD_STALL_CYCLES - 1;
  localparam int FLUSH_INIT = (BRANCH_PENALTY > 0) ? BRANCH_PENALTY - 1 : 0;

  state_t           state;
  state_t           state_nx;
  logic [REM_W-1:0] remain;
  logic [REM_W-1:0] remain_nx;
  logic             capture;
  logic             hazard;

  // Register $0 is hardwired to zero, so a load that targets it creates no dependency.
  assign hazard = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      remain           <= '0;
      if_redirect_addr <= '0;
    end else begin
      state  <= state_nx;
      remain <= remain_nx;
      if (capture) begin
        if_redirect_addr <= branch_target;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    capture   = 1'b0;
    case (state)
      RUN: begin
        // A branch wins over a same-cycle hazard. The stalled instruction is on the wrong path.
        if (branch_taken) begin
          state_nx = REDIRECT;
          capture  = 1'b1;
        end else if (hazard) begin
          state_nx  = STALL;
          remain_nx = REM_W'(STALL_INIT);
        end
      end
      STALL: begin
        if (branch_taken) begin
          state_nx = REDIRECT;
          capture  = 1'b1;
        end else if (remain == '0) begin
          state_nx = RUN;
        end else begin
          remain_nx = remain - REM_W'(1);
        end
      end
      REDIRECT: begin
        // Branches and hazards seen here come from wrong-path instructions, so they are ignored.
        if (BRANCH_PENALTY > 0) begin
          state_nx  = FLUSH;
          remain_nx = REM_W'(FLUSH_INIT);
        end else begin
          state_nx = RUN;
        end
      end
      FLUSH: begin
        if (remain == '0) begin
          state_nx = RUN;
        end else begin
          remain_nx = remain - REM_W'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Moore decode. Stall and redirect are mutually exclusive by construction.
  always_comb begin
    if_stall    = 1'b0;
    if_redirect = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      STALL: begin
        if_stall    = 1'b1;
        idex_bubble = 1'b1;
      end
      REDIRECT: begin
        if_redirect = 1'b1;
        ifid_flush  = 1'b1;
      end
      FLUSH:   ifid_flush = 1'b1;
      default: ;
    endcase
  end

  sat_counter #(.WIDTH(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (if_stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - scoreboard bench for fetch_hazard_ctrl

module tb_fetch_hazard_ctrl;

  typedef struct packed {
    logic        st;
    logic        rd;
    logic        fl;
    logic        bb;
    logic [31:0] addr;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    bit    sel;
    obs_t  exp;
    string nm;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        cnt_clr = 1'b0;

  logic        a_st, a_rd, a_fl, a_bb;
  logic [31:0] a_addr;
  logic [15:0] a_sc, a_fc;
  logic        b_st, b_rd, b_fl, b_bb;
  logic [31:0] b_addr;
  logic [3:0]  b_sc, b_fc;

  int n_chk  = 0;
  int n_pass = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  fetch_hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_a), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .branch_target(branch_target), .cnt_clr(cnt_clr), .if_stall(a_st),
    .if_redirect(a_rd), .if_redirect_addr(a_addr), .ifid_flush(a_fl),
    .idex_bubble(a_bb), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  fetch_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(1), .COUNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .branch_target(branch_target), .cnt_clr(cnt_clr), .if_stall(b_st),
    .if_redirect(b_rd), .if_redirect_addr(b_addr), .ifid_flush(b_fl),
    .idex_bubble(b_bb), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  function automatic obs_t ex(logic st, logic rd, logic fl, logic bb,
                              logic [31:0] a, int sc, int fc);
    obs_t o;
    o.st = st; o.rd = rd; o.fl = fl; o.bb = bb;
    o.addr = a; o.sc = 16'(sc); o.fc = 16'(fc);
    return o;
  endfunction

  function automatic obs_t cur(bit sel);
    if (sel) return {b_st, b_rd, b_fl, b_bb, b_addr, 16'(b_sc), 16'(b_fc)};
    return {a_st, a_rd, a_fl, a_bb, a_addr, a_sc, a_fc};
  endfunction

  function automatic int sat15(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic compare(string nm, obs_t got, obs_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got st=%b rd=%b fl=%b bb=%b addr=%h sc=%0d fc=%0d want st=%b rd=%b fl=%b bb=%b addr=%h sc=%0d fc=%0d",
                  nm, got.st, got.rd, got.fl, got.bb, got.addr, got.sc, got.fc,
                  want.st, want.rd, want.fl, want.bb, want.addr, want.sc, want.fc);
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
  task automatic apply(logic [4:0] rs, logic [4:0] rt, logic ur, logic mr, logic [4:0] ert,
                       logic bt, logic [31:0] tgt, logic clr, bit sel, obs_t e, string nm);
    sb_t s;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr; ex_rt = ert;
    branch_taken = bt; branch_target = tgt; cnt_clr = clr;
    s.sel = sel; s.exp = e; s.nm = nm;
    sb.push_back(s);
  endtask

  task automatic idle(bit sel, obs_t e, string nm);
    apply(0, 0, 0, 0, 0, 0, 0, 0, sel, e, nm);
  endtask

  task automatic hazard(bit sel, obs_t e, string nm);
    apply(8, 0, 0, 1, 8, 0, 0, 0, sel, e, nm);
  endtask

  task automatic branch(logic [31:0] tgt, bit sel, obs_t e, string nm);
    apply(0, 0, 0, 0, 0, 1, tgt, 0, sel, e, nm);
  endtask

  task automatic clear(bit sel, obs_t e, string nm);
    apply(0, 0, 0, 0, 0, 0, 0, 1, sel, e, nm);
  endtask

  // Monitor: outputs are compared just after each rising edge.
  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        s = sb.pop_front();
        compare(s.nm, cur(s.sel), s.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    idle(0, ex(0, 0, 0, 0, 0, 0, 0), "a_in_reset");
    @(negedge clk);
    rst_a = 1'b1;

    for (int i = 0; i < 10; i++) idle(0, ex(0, 0, 0, 0, 0, 0, 0), "a_idle");
    hazard(0, ex(1, 0, 0, 1, 0, 0, 0), "a_stall");
    idle(0, ex(0, 0, 0, 0, 0, 1, 0), "a_stall_end");
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0), "a_r0_no_stall");
    branch(32'h40, 0, ex(0, 1, 1, 0, 32'h40, 1, 0), "a_redirect");
    idle(0, ex(0, 0, 1, 0, 32'h40, 1, 1), "a_flush");
    idle(0, ex(0, 0, 0, 0, 32'h40, 1, 2), "a_run_after_flush");
    apply(8, 0, 0, 1, 8, 1, 32'h80, 0, 0, ex(0, 1, 1, 0, 32'h80, 1, 2), "a_branch_beats_hazard");
    idle(0, ex(0, 0, 1, 0, 32'h80, 1, 3), "a_flush2");
    branch(32'h100, 0, ex(0, 0, 0, 0, 32'h80, 1, 4), "a_branch_in_flush_ignored");
    idle(0, ex(0, 0, 0, 0, 32'h80, 1, 4), "a_addr_held");
    apply(1, 5, 0, 1, 5, 0, 0, 0, 0, ex(0, 0, 0, 0, 32'h80, 1, 4), "a_rt_unused");
    apply(1, 5, 1, 1, 5, 0, 0, 0, 0, ex(1, 0, 0, 1, 32'h80, 1, 4), "a_rt_used");
    idle(0, ex(0, 0, 0, 0, 32'h80, 2, 4), "a_rt_stall_end");
    clear(0, ex(0, 0, 0, 0, 32'h80, 0, 0), "a_clr");
    branch(32'h200, 0, ex(0, 1, 1, 0, 32'h200, 0, 0), "a_redirect3");
    idle(0, ex(0, 0, 1, 0, 32'h200, 0, 1), "a_flush3");

    // Asynchronous reset in the middle of FLUSH.
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    compare("a_async_reset", cur(0), ex(0, 0, 0, 0, 0, 0, 0));
    idle(0, ex(0, 0, 0, 0, 0, 0, 0), "a_held_reset");

    @(negedge clk);
    rst_b = 1'b1;
    idle(1, ex(0, 0, 0, 0, 0, 0, 0), "b_idle");
    hazard(1, ex(1, 0, 0, 1, 0, 0, 0), "b_stall");
    branch(32'h44, 1, ex(0, 1, 1, 0, 32'h44, 1, 0), "b_branch_aborts_stall");
    idle(1, ex(0, 0, 1, 0, 32'h44, 1, 1), "b_flush");
    idle(1, ex(0, 0, 0, 0, 32'h44, 1, 2), "b_run");
    hazard(1, ex(1, 0, 0, 1, 32'h44, 1, 2), "b_stall3_c1");
    idle(1, ex(1, 0, 0, 1, 32'h44, 2, 2), "b_stall3_c2");
    idle(1, ex(1, 0, 0, 1, 32'h44, 3, 2), "b_stall3_c3");
    idle(1, ex(0, 0, 0, 0, 32'h44, 4, 2), "b_stall3_end");

    s = 4;
    for (int k = 0; k < 6; k++) begin
      hazard(1, ex(1, 0, 0, 1, 32'h44, s, 2), "b_sat_c1");
      idle(1, ex(1, 0, 0, 1, 32'h44, sat15(s + 1), 2), "b_sat_c2");
      idle(1, ex(1, 0, 0, 1, 32'h44, sat15(s + 2), 2), "b_sat_c3");
      idle(1, ex(0, 0, 0, 0, 32'h44, sat15(s + 3), 2), "b_sat_end");
      s = sat15(s + 3);
    end
    idle(1, ex(0, 0, 0, 0, 32'h44, 15, 2), "b_sat_hold");
    clear(1, ex(0, 0, 0, 0, 32'h44, 0, 0), "b_clr");

    hazard(1, ex(1, 0, 0, 1, 32'h44, 0, 0), "b_clr_stall_c1");
    clear(1, ex(1, 0, 0, 1, 32'h44, 0, 0), "b_clr_beats_inc");
    idle(1, ex(1, 0, 0, 1, 32'h44, 1, 0), "b_clr_stall_c3");
    idle(1, ex(0, 0, 0, 0, 32'h44, 2, 0), "b_clr_stall_end");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
